// File: rtl/udp_vlg_tx_buf.sv
// udp_vlg_tx_buf
//   Store-and-forward payload buffer placed directly in front of the UDP
//   transmit stage. It takes one user datagram as a byte stream, counts its
//   length and latches the addressing meta. It then offers the datagram to
//   UDP tx through the rdy/ack/req/done handshake and streams the payload on
//   request. Only one datagram is held at a time; the user side is
//   back-pressured while a datagram is pending or being transmitted.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   in_dat/val/eof    user byte stream; accepted only while in_rdy=1
//   in_rdy            buffer accepting bytes (IDLE, FILL, DISCARD)
//   in_dst_ip/port,
//   in_src_port       addressing, sampled with the first accepted byte
//   out_dat/val/sof/
//   eof/err           payload stream to UDP tx (out_err tied 0)
//   out_rdy           datagram and meta ready for UDP tx
//   out_ack           UDP tx accepted the meta
//   out_req           UDP tx requests the payload (header sent)
//   out_done          UDP tx finished the frame
//   meta_*            UDP length (payload + 8) and latched addressing
//   err_ovf           one-cycle pulse: datagram over MAX_PAYLOAD, dropped
//   err_tmo           one-cycle pulse: no ack within TIMEOUT, dropped
module udp_vlg_tx_buf #(
   parameter int MAX_PAYLOAD = 1472,
   parameter int DEPTH       = 2048,
   parameter int TIMEOUT     = 65535
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  in_dat,
   input  logic        in_val,
   input  logic        in_eof,
   output logic        in_rdy,
   input  logic [31:0] in_dst_ip,
   input  logic [15:0] in_dst_port,
   input  logic [15:0] in_src_port,
   output logic [7:0]  out_dat,
   output logic        out_val,
   output logic        out_sof,
   output logic        out_eof,
   output logic        out_err,
   output logic        out_rdy,
   input  logic        out_req,
   input  logic        out_ack,
   input  logic        out_done,
   output logic [15:0] meta_length,
   output logic [31:0] meta_dst_ip,
   output logic [15:0] meta_dst_port,
   output logic [15:0] meta_src_port,
   output logic        err_ovf,
   output logic        err_tmo
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(MAX_PAYLOAD + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_DISCARD,
      S_PEND,
      S_WAIT_REQ,
      S_SEND,
      S_WAIT_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   count_q, count_d;
   logic [CW-1:0]   rd_q, rd_d;
   logic [TW-1:0]   tmr_q, tmr_d;
   logic [15:0]     len_q, len_d;
   logic [31:0]     ip_q, ip_d;
   logic [15:0]     dport_q, dport_d;
   logic [15:0]     sport_q, sport_d;
   logic            done_seen_q, done_seen_d;
   logic            ovf_q, ovf_d;
   logic            tmo_q, tmo_d;
   logic            oval_q, oval_d;
   logic            osof_q, osof_d;
   logic            oeof_q, oeof_d;
   logic [7:0]      odat_q;

   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic            rd_en;
   logic [AW-1:0]   rd_addr;

   logic [7:0]      mem_q [DEPTH];

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      rd_d        = rd_q;
      tmr_d       = tmr_q;
      len_d       = len_q;
      ip_d        = ip_q;
      dport_d     = dport_q;
      sport_d     = sport_q;
      done_seen_d = done_seen_q;
      ovf_d       = 1'b0;
      tmo_d       = 1'b0;
      oval_d      = 1'b0;
      osof_d      = 1'b0;
      oeof_d      = 1'b0;
      wr_en       = 1'b0;
      wr_addr     = AW'(count_q);
      rd_en       = 1'b0;
      rd_addr     = AW'(rd_q);
      in_rdy      = 1'b0;

      case (state_q)
         S_IDLE: begin
            in_rdy = 1'b1;
            if (in_val) begin
               ip_d    = in_dst_ip;
               dport_d = in_dst_port;
               sport_d = in_src_port;
               wr_en   = 1'b1;
               wr_addr = '0;
               count_d = CW'(1);
               if (in_eof) begin
                  len_d   = 16'd9;
                  tmr_d   = '0;
                  state_d = S_PEND;
               end else begin
                  state_d = S_FILL;
               end
            end
         end

         S_FILL: begin
            in_rdy = 1'b1;
            if (in_val) begin
               // A full buffer means this byte is number MAX_PAYLOAD+1.
               // An eof on that very byte already ends the datagram, so
               // there is nothing left to discard.
               if (count_q == CW'(MAX_PAYLOAD)) begin
                  ovf_d   = 1'b1;
                  count_d = '0;
                  state_d = in_eof ? S_IDLE : S_DISCARD;
               end else begin
                  wr_en   = 1'b1;
                  count_d = count_q + CW'(1);
                  if (in_eof) begin
                     len_d   = 16'(count_q) + 16'd9;
                     tmr_d   = '0;
                     state_d = S_PEND;
                  end
               end
            end
         end

         S_DISCARD: begin
            in_rdy = 1'b1;
            if (in_val && in_eof) begin
               state_d = S_IDLE;
            end
         end

         S_PEND: begin
            // Ack is checked first so it wins over the final timeout count.
            if (out_ack) begin
               done_seen_d = 1'b0;
               state_d     = S_WAIT_REQ;
            end else if (tmr_q == TW'(TIMEOUT - 1)) begin
               tmo_d   = 1'b1;
               count_d = '0;
               len_d   = '0;
               state_d = S_IDLE;
            end else begin
               tmr_d = tmr_q + TW'(1);
            end
         end

         S_WAIT_REQ: begin
            if (out_req) begin
               rd_en   = 1'b1;
               rd_addr = '0;
               oval_d  = 1'b1;
               osof_d  = 1'b1;
               rd_d    = CW'(1);
               if (count_q == CW'(1)) begin
                  oeof_d  = 1'b1;
                  state_d = S_WAIT_DONE;
               end else begin
                  state_d = S_SEND;
               end
            end
         end

         S_SEND: begin
            if (out_done) begin
               done_seen_d = 1'b1;
            end
            rd_en  = 1'b1;
            oval_d = 1'b1;
            if (rd_q == count_q - CW'(1)) begin
               oeof_d  = 1'b1;
               state_d = S_WAIT_DONE;
            end else begin
               rd_d = rd_q + CW'(1);
            end
         end

         S_WAIT_DONE: begin
            if (out_done || done_seen_q) begin
               done_seen_d = 1'b0;
               count_d     = '0;
               rd_d        = '0;
               state_d     = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         count_q     <= '0;
         rd_q        <= '0;
         tmr_q       <= '0;
         len_q       <= '0;
         ip_q        <= '0;
         dport_q     <= '0;
         sport_q     <= '0;
         done_seen_q <= 1'b0;
         ovf_q       <= 1'b0;
         tmo_q       <= 1'b0;
         oval_q      <= 1'b0;
         osof_q      <= 1'b0;
         oeof_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         rd_q        <= rd_d;
         tmr_q       <= tmr_d;
         len_q       <= len_d;
         ip_q        <= ip_d;
         dport_q     <= dport_d;
         sport_q     <= sport_d;
         done_seen_q <= done_seen_d;
         ovf_q       <= ovf_d;
         tmo_q       <= tmo_d;
         oval_q      <= oval_d;
         osof_q      <= osof_d;
         oeof_q      <= oeof_d;
      end
   end

   // Payload storage; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= in_dat;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         odat_q <= '0;
      end else if (rd_en) begin
         odat_q <= mem_q[rd_addr];
      end
   end

   assign out_dat       = odat_q;
   assign out_val       = oval_q;
   assign out_sof       = osof_q;
   assign out_eof       = oeof_q;
   assign out_err       = 1'b0;
   assign out_rdy       = (state_q == S_PEND);
   assign meta_length   = len_q;
   assign meta_dst_ip   = ip_q;
   assign meta_dst_port = dport_q;
   assign meta_src_port = sport_q;
   assign err_ovf       = ovf_q;
   assign err_tmo       = tmo_q;

endmodule

// File: tb/tb_udp_vlg_tx_buf.sv
// tb_udp_vlg_tx_buf
//   Directed sequence with randomized payload, addressing and idle gaps.
//   Expected bytes come from the payload queue, expected length is payload
//   count plus 8, and the timeout is counted in clock cycles from out_rdy.
module tb_udp_vlg_tx_buf;

   localparam int MAXP = 1472;
   localparam int TMO  = 100;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  in_dat;
   logic        in_val;
   logic        in_eof;
   logic        in_rdy;
   logic [31:0] in_dst_ip;
   logic [15:0] in_dst_port;
   logic [15:0] in_src_port;
   logic [7:0]  out_dat;
   logic        out_val;
   logic        out_sof;
   logic        out_eof;
   logic        out_err;
   logic        out_rdy;
   logic        out_req;
   logic        out_ack;
   logic        out_done;
   logic [15:0] meta_length;
   logic [31:0] meta_dst_ip;
   logic [15:0] meta_dst_port;
   logic [15:0] meta_src_port;
   logic        err_ovf;
   logic        err_tmo;

   int errors = 0;
   int checks = 0;
   logic [7:0] pay[$];

   always #5 clk = ~clk;

   udp_vlg_tx_buf #(
      .MAX_PAYLOAD (MAXP),
      .DEPTH       (2048),
      .TIMEOUT     (TMO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .in_dat        (in_dat),
      .in_val        (in_val),
      .in_eof        (in_eof),
      .in_rdy        (in_rdy),
      .in_dst_ip     (in_dst_ip),
      .in_dst_port   (in_dst_port),
      .in_src_port   (in_src_port),
      .out_dat       (out_dat),
      .out_val       (out_val),
      .out_sof       (out_sof),
      .out_eof       (out_eof),
      .out_err       (out_err),
      .out_rdy       (out_rdy),
      .out_req       (out_req),
      .out_ack       (out_ack),
      .out_done      (out_done),
      .meta_length   (meta_length),
      .meta_dst_ip   (meta_dst_ip),
      .meta_dst_port (meta_dst_port),
      .meta_src_port (meta_src_port),
      .err_ovf       (err_ovf),
      .err_tmo       (err_tmo)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic fill_random(input int len);
      pay.delete();
      for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
   endtask

   // Drives len bytes (payload from pay, random beyond it) with random gaps.
   task automatic send_bytes(input int len, input bit eof_last,
                             input logic [31:0] ip, input logic [15:0] dp,
                             input logic [15:0] sp, output int ovf_idx,
                             output int ovf_cnt, output bit rdy_seen);
      ovf_idx  = -1;
      ovf_cnt  = 0;
      rdy_seen = 1'b0;
      for (int i = 0; i < len; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            in_val = 1'b0;
            tick();
         end
         in_val = 1'b1;
         in_dat = (i < pay.size()) ? pay[i] : 8'($urandom);
         in_eof = eof_last && (i == len - 1);
         if (i == 0) begin
            in_dst_ip   = ip;
            in_dst_port = dp;
            in_src_port = sp;
         end else begin
            in_dst_ip   = $urandom;
            in_dst_port = 16'($urandom);
            in_src_port = 16'($urandom);
         end
         tick();
         if (err_ovf === 1'b1) begin
            ovf_cnt++;
            if (ovf_idx < 0) ovf_idx = i;
         end
         if (out_rdy === 1'b1) rdy_seen = 1'b1;
      end
      in_val = 1'b0;
      in_eof = 1'b0;
   endtask

   // Issues req, collects the stream and compares it with pay.
   task automatic stream(input string nm, input int len, input bit hold_req,
                         input bit early_done);
      int k;
      k = 0;
      for (int c = 0; c < len + 10; c++) begin
         if (out_val === 1'b1) begin
            if (k < len)
               check({nm, "_byte"}, {out_dat, out_sof, out_eof},
                     {pay[k], 1'(k == 0), 1'(k == len - 1)});
            k++;
         end else if (k > 0) begin
            break;
         end
         out_req  = hold_req || (c == 0);
         out_done = early_done && (k == 1);
         in_val   = 1'b1;
         in_dat   = 8'($urandom);
         in_eof   = 1'($urandom);
         tick();
      end
      out_req  = 1'b0;
      out_done = 1'b0;
      in_val   = 1'b0;
      in_eof   = 1'b0;
      check({nm, "_len"}, k, len);
   endtask

   task automatic run_dgram(input string nm, input int len, input logic [31:0] ip,
                            input logic [15:0] dp, input logic [15:0] sp,
                            input bit hold_req, input bit early_done);
      int oi, oc;
      bit rs;
      send_bytes(len, 1'b1, ip, dp, sp, oi, oc, rs);
      check({nm, "_no_ovf"}, oc, 0);
      check({nm, "_out_rdy"}, out_rdy, 1);
      check({nm, "_in_rdy_pend"}, in_rdy, 0);
      check({nm, "_meta_len"}, meta_length, len + 8);
      check({nm, "_meta"}, {meta_dst_ip, meta_dst_port, meta_src_port}, {ip, dp, sp});
      for (int i = 0; i < 2; i++) begin
         in_val = 1'b1;
         in_dat = 8'($urandom);
         in_eof = 1'($urandom);
         tick();
      end
      in_val  = 1'b0;
      in_eof  = 1'b0;
      out_ack = 1'b1;
      tick();
      out_ack = 1'b0;
      check({nm, "_rdy_after_ack"}, out_rdy, 0);
      check({nm, "_len_held"}, meta_length, len + 8);
      repeat ($urandom_range(0, 3)) tick();
      stream(nm, len, hold_req, early_done);
      if (!early_done) begin
         check({nm, "_in_rdy_wait_done"}, in_rdy, 0);
         out_done = 1'b1;
         tick();
         out_done = 1'b0;
      end
      check({nm, "_in_rdy_after"}, in_rdy, 1);
      check({nm, "_val_after"}, out_val, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int oi, oc, k, tmo_at;
      bit rs;

      rst = 1'b1;
      in_dat = '0; in_val = 1'b0; in_eof = 1'b0;
      in_dst_ip = '0; in_dst_port = '0; in_src_port = '0;
      out_req = 1'b0; out_ack = 1'b0; out_done = 1'b0;
      repeat (3) tick();

      // Reset state
      check("rst_in_rdy", in_rdy, 1);
      check("rst_outs", {out_rdy, out_val, out_sof, out_eof, out_err, err_ovf, err_tmo}, 0);
      check("rst_dat", out_dat, 0);
      check("rst_meta", {meta_length, meta_dst_ip, meta_dst_port, meta_src_port}, 0);
      rst = 1'b0;
      tick();

      // 4-byte datagram, req held as a level
      pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      run_dgram("t1", 4, {8'd192, 8'd168, 8'd1, 8'd10}, 16'd1234, 16'd5000, 1'b1, 1'b0);

      // 1-byte datagram
      fill_random(1);
      run_dgram("t2", 1, $urandom, 16'($urandom), 16'($urandom), 1'b0, 1'b0);

      // Overflow: 1473 bytes without eof, then tail swallowed
      pay.delete();
      send_bytes(MAXP + 1, 1'b0, $urandom, 16'd1, 16'd2, oi, oc, rs);
      check("ovf_count", oc, 1);
      check("ovf_byte", oi, MAXP);
      check("ovf_no_rdy", rs, 0);
      send_bytes(4, 1'b1, $urandom, 16'd3, 16'd4, oi, oc, rs);
      check("disc_no_ovf", oc, 0);
      check("disc_no_rdy", rs, 0);
      check("disc_idle", {in_rdy, out_rdy}, 2'b10);

      // Following 2-byte datagram, out_done arrives during SEND
      fill_random(2);
      run_dgram("t3", 2, $urandom, 16'($urandom), 16'($urandom), 1'b0, 1'b1);

      // Ack timeout
      fill_random(3);
      send_bytes(3, 1'b1, $urandom, 16'd7, 16'd8, oi, oc, rs);
      check("tmo_rdy", out_rdy, 1);
      tmo_at = -1;
      for (int c = 1; c <= TMO + 20; c++) begin
         tick();
         if (err_tmo === 1'b1) begin
            tmo_at = c;
            break;
         end
      end
      check("tmo_cycle", tmo_at, TMO);
      check("tmo_state", {out_rdy, in_rdy}, 2'b01);
      tick();
      check("tmo_pulse", err_tmo, 0);

      // Ack on the final timeout count wins
      fill_random(6);
      send_bytes(6, 1'b1, $urandom, 16'd9, 16'd10, oi, oc, rs);
      repeat (TMO - 1) tick();
      out_ack = 1'b1;
      tick();
      out_ack = 1'b0;
      check("ackwin_tmo", err_tmo, 0);
      check("ackwin_state", {out_rdy, in_rdy}, 2'b00);
      stream("ackwin", 6, 1'b0, 1'b0);
      out_done = 1'b1;
      tick();
      out_done = 1'b0;
      check("ackwin_idle", in_rdy, 1);

      // Maximum payload
      fill_random(MAXP);
      run_dgram("tmax", MAXP, $urandom, 16'($urandom), 16'($urandom), 1'b0, 1'b0);

      // Reset during SEND byte 10
      fill_random(20);
      send_bytes(20, 1'b1, $urandom, 16'd11, 16'd12, oi, oc, rs);
      out_ack = 1'b1;
      tick();
      out_ack = 1'b0;
      out_req = 1'b1;
      k = 0;
      for (int c = 0; c < 40; c++) begin
         if (out_val === 1'b1) begin
            if (k == 10) break;
            k++;
         end
         tick();
         out_req = 1'b0;
      end
      out_req = 1'b0;
      check("rst_send_reached", k, 10);
      check("rst_send_byte10", out_dat, pay[10]);
      rst = 1'b1;
      tick();
      check("rst_send_state", {out_val, out_rdy, in_rdy}, 3'b001);
      check("rst_send_len", meta_length, 0);
      rst = 1'b0;
      tick();
      fill_random(5);
      run_dgram("t_after_rst", 5, $urandom, 16'($urandom), 16'($urandom), 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/udp_vlg_tx_buf.md
Name: udp_vlg_tx_buf

Overview:
- Store-and-forward payload buffer directly upstream of the UDP transmit stage.
- Accepts one user datagram as a byte stream and counts its length, then presents the datagram to UDP tx through the rdy/ack/req/done handshake and streams the payload on request.
- Holds exactly one datagram; the user side is back-pressured while a datagram is pending or transmitting.

Parameters:
- MAX_PAYLOAD, 1472: maximum payload bytes per datagram (Ethernet MTU minus IPv4/UDP headers).
- DEPTH, 2048: buffer size in bytes; power of 2, ≥ MAX_PAYLOAD.
- TIMEOUT, 65535: cycles to wait for ack after rdy before dropping the datagram.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- in_dat  in  8  user payload byte
- in_val  in  1  in_dat valid; accepted only when in_rdy=1
- in_eof  in  1  last byte of datagram; qualified by in_val
- in_rdy  out  1  buffer accepting bytes
- in_dst_ip  in  32  destination IPv4; sampled with first accepted byte
- in_dst_port  in  16  destination port; sampled with first byte
- in_src_port  in  16  source port; sampled with first byte
- out_dat  out  8  payload byte to UDP tx
- out_val  out  1  out_dat valid
- out_sof  out  1  first payload byte
- out_eof  out  1  last payload byte
- out_err  out  1  stream error; tied 0
- out_rdy  out  1  datagram and meta ready for UDP tx
- out_req  in  1  UDP tx requests payload (header done)
- out_ack  in  1  UDP tx accepted meta
- out_done  in  1  UDP tx finished frame
- meta_length  out  16  UDP length = payload bytes + 8
- meta_dst_ip  out  32  latched destination IP
- meta_dst_port  out  16  latched destination port
- meta_src_port  out  16  latched source port
- err_ovf  out  1  one-cycle pulse: datagram exceeded MAX_PAYLOAD, dropped
- err_tmo  out  1  one-cycle pulse: ack timeout, datagram dropped

Behaviour:
- Reset: all outputs 0 except in_rdy=1. State=IDLE, write/read counters=0, meta registers=0.
- States:
  - IDLE: in_rdy=1. First in_val latches dst_ip/dst_port/src_port, writes the byte at address 0, count=1, goes to FILL. If in_eof is set on that same byte, goes straight to PEND (1-byte datagram).
  - FILL: in_rdy=1. Each in_val writes buf[count] and increments count.
    - in_eof with count+1 ≤ MAX_PAYLOAD: in_rdy drops the next cycle, meta_length=count+1+8, goes to PEND.
    - Byte number MAX_PAYLOAD+1 arriving without eof: err_ovf pulses, goes to DISCARD.
  - DISCARD: in_rdy=1; bytes are swallowed until in_val&in_eof, then returns to IDLE. A new datagram needs a fresh first byte.
  - PEND: out_rdy=1 with meta stable; timeout counter runs.
    - out_ack → out_rdy=0 the next cycle, goes to WAIT_REQ.
    - Counter reaching TIMEOUT → err_tmo pulses, buffer is cleared, returns to IDLE.
    - out_ack in the same cycle as the final timeout count: ack wins.
  - WAIT_REQ: waits for out_req=1 (level or pulse), then goes to SEND.
  - SEND:
    - Read latency is 1: out_val=1 starting the cycle after req is sampled, one byte per cycle, no gaps.
    - out_sof is set on byte 0; out_eof is set on byte length-9.
    - After eof, goes to WAIT_DONE.
    - out_req is ignored while in SEND.
  - WAIT_DONE: out_done → IDLE with in_rdy=1 the next cycle. out_done arriving earlier, during SEND, is latched and honoured after eof.
- Widths: count is 11 bits (sized for MAX_PAYLOAD); meta_length is 16 bits, zero-extended.
- in_val while in_rdy=0 is ignored; no data is stored.
- rst at any point, including mid-SEND, returns to the reset state within 1 cycle. No partial frame continues after reset.

Test Plan:
- 4-byte datagram 0xDE,0xAD,0xBE,0xEF, dst 192.168.1.10:1234, src 5000 → out_rdy=1, meta_length=12, meta fields match. Ack, then req → out_val for 4 cycles with bytes in order, sof on byte 0, eof on byte 3. out_done → in_rdy=1.
- 1-byte datagram (in_val&in_eof on first byte) → meta_length=9; SEND has sof and eof together on a single cycle.
- 1473 bytes with no eof → err_ovf pulses once on byte 1473; rest swallowed until eof; no out_rdy. A following 2-byte datagram transmits normally.
- Valid datagram with out_ack held 0 and TIMEOUT=100 → err_tmo pulses exactly 100 cycles after out_rdy rose; out_rdy=0, in_rdy=1.
- 1472-byte datagram → meta_length=1480; all 1472 bytes streamed contiguously. in_val during PEND/SEND is not accepted.
- rst asserted during SEND byte 10 → next cycle out_val=0, out_rdy=0, in_rdy=1. A new datagram works afterwards.
